// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FP sequencer.
//   OP_FP opcode, funct7 decode constants, FPU operation codes,
//   rounding-mode encodings and the sequencer state type.
package fpu_pkg;

   localparam logic [6:0] OP_FP = 7'b1010011;

   localparam logic [6:0] F7_ADD    = 7'b0000000;
   localparam logic [6:0] F7_SUB    = 7'b0000100;
   localparam logic [6:0] F7_MUL    = 7'b0001000;
   localparam logic [6:0] F7_DIV    = 7'b0001100;
   localparam logic [6:0] F7_SQRT   = 7'b0101100;
   localparam logic [6:0] F7_MINMAX = 7'b0010100;
   localparam logic [6:0] F7_CMP    = 7'b1010000;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_MUL  = 4'd2,
      OP_DIV  = 4'd3,
      OP_SQRT = 4'd4,
      OP_MIN  = 4'd5,
      OP_MAX  = 4'd6,
      OP_EQ   = 4'd7,
      OP_LT   = 4'd8,
      OP_LE   = 4'd9
   } fpu_op_e;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [2:0] RM_DYN = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WB    = 3'd3,
      ST_ABORT = 3'd4
   } fsm_state_e;

   // Compares write the integer regfile; everything else targets the FP regfile.
   function automatic logic is_int_dst(fpu_op_e op);
      return (op >= OP_EQ);
   endfunction

endpackage

// File: rtl/fpu_dec.sv
// fpu_dec: combinational OP-FP decoder.
//   inputs : opcode, funct7, funct3, rs2 fields of the decode-stage
//            instruction, frm_i (dynamic rounding mode)
//   outputs: is_opfp_o (opcode matches OP-FP), legal_o (supported encoding),
//            op_o, rm_o (resolved rounding mode), int_dst_o
module fpu_dec
   import fpu_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [6:0] funct7_i,
   input  logic [2:0] funct3_i,
   input  logic [4:0] rs2_i,
   input  logic [2:0] frm_i,
   output logic       is_opfp_o,
   output logic       legal_o,
   output fpu_op_e    op_o,
   output logic [2:0] rm_o,
   output logic       int_dst_o
);

   logic       known;
   logic       arith;
   logic [2:0] rm_res;

   always_comb begin
      op_o   = OP_ADD;
      known  = 1'b0;
      arith  = 1'b0;
      case (funct7_i)
         F7_ADD:  begin op_o = OP_ADD;  known = 1'b1; arith = 1'b1; end
         F7_SUB:  begin op_o = OP_SUB;  known = 1'b1; arith = 1'b1; end
         F7_MUL:  begin op_o = OP_MUL;  known = 1'b1; arith = 1'b1; end
         F7_DIV:  begin op_o = OP_DIV;  known = 1'b1; arith = 1'b1; end
         F7_SQRT: begin op_o = OP_SQRT; known = (rs2_i == 5'd0); arith = 1'b1; end
         F7_MINMAX: begin
            case (funct3_i)
               3'b000:  begin op_o = OP_MIN; known = 1'b1; end
               3'b001:  begin op_o = OP_MAX; known = 1'b1; end
               default: ;
            endcase
         end
         F7_CMP: begin
            case (funct3_i)
               3'b010:  begin op_o = OP_EQ; known = 1'b1; end
               3'b001:  begin op_o = OP_LT; known = 1'b1; end
               3'b000:  begin op_o = OP_LE; known = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase

      // funct3 doubles as the static rounding mode for arithmetic ops;
      // a reserved mode (either static or via frm) makes the op illegal.
      rm_res    = (funct3_i == RM_DYN) ? frm_i : funct3_i;
      rm_o      = arith ? rm_res : RM_RNE;
      is_opfp_o = (opcode_i == OP_FP);
      legal_o   = is_opfp_o && known && !(arith && (rm_res > RM_RMM));
      int_dst_o = is_int_dst(op_o);
   end

endmodule

// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: multi-cycle sequencer issuing OP-FP instructions to the FPU.
//   clk_i, rst_ni        : clock, async active-low reset
//   inst_i, inst_vld_i   : decode-stage instruction and valid
//   frm_i                : dynamic rounding mode
//   flush_i              : kill in-flight op / suppress acceptance
//   fflags_clr_i         : clear sticky flags
//   fpu_ready_i/done_i   : FPU start acceptance / result pulse
//   fpu_exc_i            : exceptions, valid with fpu_done_i
//   stall_o              : hold PC/IF/ID
//   fpu_start_o, fpu_op_o, fpu_rm_o, fpu_kill_o : FPU request side
//   frd_wren_o, rd_wren_o, rd_addr_o            : regfile writeback
//   fflags_o             : sticky NV,DZ,OF,UF,NX
//   illegal_o, err_o     : unsupported encoding / timeout pulses
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a legal OP-FP instruction
// ST_ISSUE | fpu_start_o held until fpu_ready_i
// ST_WAIT  | waiting for fpu_done_i, timeout down-counter running
// ST_WB    | one-cycle regfile write and fflags accumulate
// ST_ABORT | one-cycle timeout abort: kill FPU, raise err_o
module fpu_seq_ctrl
   import fpu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = $clog2(TIMEOUT_CYC)
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] inst_i,
   input  logic        inst_vld_i,
   input  logic [2:0]  frm_i,
   input  logic        flush_i,
   input  logic        fflags_clr_i,
   input  logic        fpu_ready_i,
   input  logic        fpu_done_i,
   input  logic [4:0]  fpu_exc_i,
   output logic        stall_o,
   output logic        fpu_start_o,
   output logic [3:0]  fpu_op_o,
   output logic [2:0]  fpu_rm_o,
   output logic        fpu_kill_o,
   output logic        frd_wren_o,
   output logic        rd_wren_o,
   output logic [4:0]  rd_addr_o,
   output logic [4:0]  fflags_o,
   output logic        illegal_o,
   output logic        err_o
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

   fsm_state_e       state_q;
   fpu_op_e          op_q;
   logic [2:0]       rm_q;
   logic [4:0]       rd_q;
   logic             int_dst_q;
   logic [4:0]       exc_q;
   logic [4:0]       fflags_q;
   logic [CNT_W-1:0] cnt_q;

   logic             dec_opfp;
   logic             dec_legal;
   fpu_op_e          dec_op;
   logic [2:0]       dec_rm;
   logic             dec_int_dst;
   logic             accept;
   logic             in_flight;
   logic             unused_rs1;

   // rs1 carries no sequencing information.
   assign unused_rs1 = ^inst_i[19:15];

   fpu_dec u_dec (
      .opcode_i  (inst_i[6:0]),
      .funct7_i  (inst_i[31:25]),
      .funct3_i  (inst_i[14:12]),
      .rs2_i     (inst_i[24:20]),
      .frm_i     (frm_i),
      .is_opfp_o (dec_opfp),
      .legal_o   (dec_legal),
      .op_o      (dec_op),
      .rm_o      (dec_rm),
      .int_dst_o (dec_int_dst)
   );

   assign accept    = (state_q == ST_IDLE) && inst_vld_i && dec_legal && !flush_i;
   assign in_flight = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

   // Acceptance stalls in the same cycle so the instruction is held in ID.
   assign stall_o     = accept || in_flight;
   assign illegal_o   = (state_q == ST_IDLE) && inst_vld_i && dec_opfp && !dec_legal && !flush_i;
   assign fpu_start_o = (state_q == ST_ISSUE);
   assign fpu_kill_o  = (state_q == ST_ABORT) || (in_flight && flush_i);
   assign err_o       = (state_q == ST_ABORT);
   assign frd_wren_o  = (state_q == ST_WB) && !int_dst_q;
   assign rd_wren_o   = (state_q == ST_WB) && int_dst_q;
   assign fpu_op_o    = op_q;
   assign fpu_rm_o    = rm_q;
   assign rd_addr_o   = rd_q;
   assign fflags_o    = fflags_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_ADD;
         rm_q      <= RM_RNE;
         rd_q      <= 5'd0;
         int_dst_q <= 1'b0;
         exc_q     <= 5'd0;
         fflags_q  <= 5'd0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q      <= dec_op;
                  rm_q      <= dec_rm;
                  rd_q      <= inst_i[11:7];
                  int_dst_q <= dec_int_dst;
                  state_q   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (flush_i) begin
                  state_q <= ST_IDLE;
               end else if (fpu_ready_i) begin
                  cnt_q   <= CNT_LOAD;
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Priority: flush, then done, then timeout terminal count.
               if (flush_i) begin
                  state_q <= ST_IDLE;
               end else if (fpu_done_i) begin
                  exc_q   <= fpu_exc_i;
                  state_q <= ST_WB;
               end else if (cnt_q == '0) begin
                  state_q <= ST_ABORT;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_WB:    state_q <= ST_IDLE;
            ST_ABORT: state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase

         // Clear takes effect before the writeback OR.
         if (state_q == ST_WB) begin
            fflags_q <= (fflags_clr_i ? 5'd0 : fflags_q) | exc_q;
         end else if (fflags_clr_i) begin
            fflags_q <= 5'd0;
         end
      end
   end

endmodule
